nrd_seq_divider: RTL

Sequential non-restoring unsigned divider for N-bit operands; it is the control/datapath stage that sits directly upstream of the N+1-bit ripple add/subtract unit. Each cycle it decides add vs subtract from the partial-remainder sign and drives the unit's mode bit. It then captures the sum back into the partial-remainder register and shifts in quotient bits. It accepts one division per start pulse and reports quotient, remainder and completion.

---
 rtl/nrd_pkg.sv | 19 +
 rtl/nrd_addsub.sv | 27 ++
 rtl/nrd_seq_divider.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nrd_pkg.sv
// Shared definitions for the non-restoring sequential divider:
// default operand width, FSM state encoding and counter sizing.
package nrd_pkg;

    localparam int NRD_DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } nrd_state_t;

    // Counter must be able to hold the value N itself, hence N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nrd_addsub.sv
// W-bit ripple-carry add/subtract unit: m=0 computes a+b, m=1 computes a-b.
// The final carry-out is not needed by the divider and is not produced.
module nrd_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_x;

    assign b_x = b ^ {W{m}};

    // Subtraction is a + ~b + 1, so the mode bit doubles as the carry-in.
    always_comb begin
        logic c;
        sum = '0;
        c   = m;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b_x[i] ^ c;
            c      = (a[i] & b_x[i]) | (c & (a[i] ^ b_x[i]));
        end
    end

endmodule

// File: rtl/nrd_seq_divider.sv
// Sequential non-restoring unsigned divider, one quotient bit per cycle.
// Optional macro NRD_DIV_ZERO_CHECK_EN adds a one-cycle divide-by-zero path.
module nrd_seq_divider
    import nrd_pkg::*;
#(
    parameter int N = NRD_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    nrd_state_t    state_q, state_d;
    logic [N:0]    a_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  m_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    shift_a;
    logic [N:0]    as_a;
    logic [N:0]    as_b;
    logic          as_m;
    logic [N:0]    as_sum;

    // ITER feeds the shifted partial remainder; FIX reuses the unit as a plain adder.
    assign shift_a = {a_q[N-1:0], q_q[N-1]};
    assign as_a    = (state_q == FIX) ? a_q  : shift_a;
    assign as_m    = (state_q == FIX) ? 1'b0 : ~a_q[N];
    assign as_b    = {1'b0, m_q};

    nrd_addsub #(.W(N + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .m   (as_m),
        .sum (as_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef NRD_DIV_ZERO_CHECK_EN
                if (start) state_d = (divisor == '0) ? ZERO : ITER;
`else
                if (start) state_d = ITER;
`endif
            end
            ITER: begin
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= '0;
                        q_q   <= dividend;
                        m_q   <= divisor;
                        cnt_q <= CW'(N);
                        busy  <= 1'b1;
                    end
                end
                ITER: begin
                    a_q   <= as_sum;
                    q_q   <= {q_q[N-2:0], ~as_sum[N]};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    // A negative final remainder is restored by one extra add.
                    if (a_q[N]) a_q <= as_sum;
                    quotient  <= q_q;
                    remainder <= a_q[N] ? as_sum[N-1:0] : a_q[N-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
`ifdef NRD_DIV_ZERO_CHECK_EN
                ZERO: begin
                    quotient  <= '1;
                    remainder <= q_q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef NRD_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (state_q == ZERO) begin
            div_by_zero <= 1'b1;
        end else if (state_q == FIX) begin
            div_by_zero <= 1'b0;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
